mpls_egress_admit: RTL and testbench
====================================

MPLS_EGRESS_ADMIT -- requirements
Module: mpls_egress_admit

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of egress ports (1..64).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each statistics counter.
REQ-003 SHALL have clk_ifc, input, Clock_int, the single block clock.
REQ-004 SHALL have sreset_ifc, input, Reset_int, synchronous active-high reset sampled on clk_ifc.
REQ-005 SHALL have egr_bus, AXIS_int.Slave, wide egress bus. tuser[SEL_W-1:0] is the destination port index, with SEL_W = max(1, clog2(NUM_PORTS)).
REQ-006 SHALL have egr_ports, AXIS_int.Master [NUM_PORTS], per-port outputs with the same DATA_BYTES as egr_bus.
REQ-007 SHALL have port_almost_full, input, NUM_PORTS bits, per-port downstream buffer congestion flag.
REQ-008 SHALL have drop_pulse, output, NUM_PORTS bits, one-cycle pulse when a packet for that port is dropped.
REQ-009 SHALL have bad_port_pulse, output, 1 bit, one-cycle pulse when a packet is dropped for an out-of-range index.
REQ-010 SHALL have fwd_pkt_cnt and drop_pkt_cnt, output, [NUM_PORTS][CNT_WIDTH], per-port counters; plus bad_port_cnt, output, CNT_WIDTH.

Function
REQ-011 SHALL run an FSM with states IDLE (awaiting SOP), FWD and DROP.
REQ-012 In IDLE, when egr_bus.tvalid is high, SHALL decide admission combinationally from tuser and port_almost_full[tuser]: forward if the index is < NUM_PORTS and not almost full, otherwise drop.
REQ-013 A forwarded packet SHALL pass with zero-cycle latency: egr_ports[sel].tvalid = egr_bus.tvalid, egr_bus.tready = egr_ports[sel].tready, with tdata, tkeep, tlast and tuser copied unchanged.
REQ-014 SHALL hold sel in a register from the SOP beat until the tlast handshake; tuser on later beats SHALL be ignored.
REQ-015 In DROP, egr_bus.tready SHALL be 1 and every egr_ports tvalid SHALL be 0 until the tlast handshake.
REQ-016 Transitions: IDLE->FWD or DROP on an SOP handshake without tlast. FWD or DROP->IDLE on a tlast handshake. A single-beat packet (SOP with tlast) SHALL remain in IDLE.
REQ-017 A port_almost_full change after SOP SHALL NOT affect the packet in flight; whole-packet granularity only.
REQ-018 Non-selected egr_ports SHALL have tvalid 0 at all times.
REQ-019 fwd_pkt_cnt[p] SHALL increment on the tlast handshake of a forwarded packet.
REQ-020 drop_pkt_cnt[p] or bad_port_cnt SHALL increment on the SOP handshake of a dropped packet, in the same cycle as drop_pulse or bad_port_pulse.
REQ-021 Counters SHALL saturate at all-ones and never wrap.
REQ-022 tvalid without tready SHALL NOT advance the FSM, pulses or counters.

Reset
REQ-023 While reset is high: FSM in IDLE, sel=0, egr_bus.tready=0, all egr_ports tvalid=0, all pulses 0, all counters 0.
REQ-024 Reset mid-packet SHALL abandon the packet. The first beat after release SHALL be treated as an SOP.

Configuration
REQ-025 With MPLS_EGRESS_ADMIT_STATS_EN defined, the counters SHALL be implemented as specified.
REQ-026 Without MPLS_EGRESS_ADMIT_STATS_EN, all counter outputs SHALL be tied to 0 and no counter flops SHALL be built. Pulses and forwarding SHALL be unaffected.

Structure
REQ-027 Package mpls_egress_pkg SHALL hold the FSM state enum, the SEL_W computation function and the default CNT_WIDTH constant.
REQ-028 A sub-module mpls_egress_port_stats (one saturating counter with an increment strobe) SHALL be instantiated per counter.
REQ-029 Elaboration checks SHALL fail if NUM_PORTS < 1 or egr_bus.USER_WIDTH < SEL_W.

Verification
REQ-030 Test: 3-beat packet, tuser=2, all ready, not almost full -> appears on port 2 only, zero latency, fwd_pkt_cnt[2]=1.
REQ-031 Test: port_almost_full[1]=1 at SOP, 4-beat packet to port 1 -> tready high for 4 cycles, no output, drop_pulse[1] for one cycle, drop_pkt_cnt[1]=1.
REQ-032 Test: NUM_PORTS=3, tuser=3 -> packet consumed, bad_port_pulse=1, bad_port_cnt=1.
REQ-033 Test: almost_full rises after SOP beat of a 5-beat packet to port 0, and tuser changes mid-packet -> all 5 beats delivered on port 0.
REQ-034 Test: back-to-back single-beat packets to ports 0,1,0 with port 1 tready stalled 3 cycles -> order preserved, FSM stays IDLE, fwd_pkt_cnt={2,1,...}.
REQ-035 Test: CNT_WIDTH=4, 17 forwarded packets -> fwd_pkt_cnt=15. Reset asserted mid-packet -> counters 0, next beat treated as SOP.

Source files
------------

// File: rtl/mpls_egress_pkg.sv
// Shared definitions for the MPLS egress admission block.
//
// Contents:
//   CNT_WIDTH_DEFAULT - default width of every statistics counter
//   state_e           - admission FSM states (idle / forwarding / dropping)
//   sel_width()       - width of the destination port index, max(1, clog2(n))
package mpls_egress_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFwd  = 2'd1,
    StDrop = 2'd2
  } state_e;

  function automatic int unsigned sel_width(input int unsigned num_ports);
    if (num_ports <= 1) begin
      return 1;
    end
    return $clog2(num_ports);
  endfunction

endpackage

// File: rtl/mpls_egress_port_stats.sv
// One saturating packet counter.
//
// Ports:
//   clk    - block clock
//   sreset - synchronous active-high reset, clears the count
//   inc    - increment strobe, one count per cycle it is high
//   count  - current value; holds at all-ones instead of wrapping
module mpls_egress_port_stats
  import mpls_egress_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (sreset) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mpls_egress_admit.sv
// MPLS egress admission: steers packets from one wide AXI-Stream bus to one of
// NUM_PORTS egress ports, dropping whole packets whose destination is congested
// (port_almost_full at SOP) or whose index is out of range.
//
// The admission decision is made combinationally on the SOP beat and frozen for
// the rest of the packet; forwarded beats pass with zero latency.
//
// Optional feature: define MPLS_EGRESS_ADMIT_STATS_EN to build the per-port
// forward/drop counters and the bad-port counter. Without it the counter outputs
// are tied to zero and no counter flops exist; pulses and forwarding are unchanged.
//
// Ports:
//   clk_ifc, sreset_ifc          - clock, synchronous active-high reset
//   egr_bus_*                    - AXI-Stream slave; tuser[SEL_W-1:0] = destination
//   egr_ports_*                  - per-port AXI-Stream masters (payload broadcast,
//                                  only the selected port's tvalid can rise)
//   port_almost_full             - per-port downstream congestion flag
//   drop_pulse, bad_port_pulse   - one-cycle pulses on the SOP handshake of a drop
//   fwd_pkt_cnt, drop_pkt_cnt    - per-port saturating packet counters
//   bad_port_cnt                 - saturating count of out-of-range drops
module mpls_egress_admit
  import mpls_egress_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned USER_WIDTH = 8
) (
  input  logic                                     clk_ifc,
  input  logic                                     sreset_ifc,
  // Wide egress bus
  input  logic                                     egr_bus_tvalid,
  output logic                                     egr_bus_tready,
  input  logic [8*DATA_BYTES-1:0]                  egr_bus_tdata,
  input  logic [DATA_BYTES-1:0]                    egr_bus_tkeep,
  input  logic                                     egr_bus_tlast,
  input  logic [USER_WIDTH-1:0]                    egr_bus_tuser,
  // Per-port outputs
  output logic [NUM_PORTS-1:0]                     egr_ports_tvalid,
  input  logic [NUM_PORTS-1:0]                     egr_ports_tready,
  output logic [NUM_PORTS-1:0][8*DATA_BYTES-1:0]   egr_ports_tdata,
  output logic [NUM_PORTS-1:0][DATA_BYTES-1:0]     egr_ports_tkeep,
  output logic [NUM_PORTS-1:0]                     egr_ports_tlast,
  output logic [NUM_PORTS-1:0][USER_WIDTH-1:0]     egr_ports_tuser,
  // Congestion and drop reporting
  input  logic [NUM_PORTS-1:0]                     port_almost_full,
  output logic [NUM_PORTS-1:0]                     drop_pulse,
  output logic                                     bad_port_pulse,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]      fwd_pkt_cnt,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]      drop_pkt_cnt,
  output logic [CNT_WIDTH-1:0]                     bad_port_cnt
);

  localparam int unsigned SEL_W = sel_width(NUM_PORTS);
  localparam int unsigned SEL_N = 1 << SEL_W;

  // Elaboration-time parameter checks
  if (NUM_PORTS < 1 || NUM_PORTS > 64) begin : g_bad_num_ports
    $error("mpls_egress_admit: NUM_PORTS must be in 1..64");
  end
  if (USER_WIDTH < SEL_W) begin : g_bad_user_width
    $error("mpls_egress_admit: USER_WIDTH is narrower than the port index");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [SEL_W-1:0] sop_idx;
  logic             idx_ok;
  logic             admit;
  logic [SEL_N-1:0] af_ext;
  logic [SEL_N-1:0] rdy_ext;
  logic [SEL_W-1:0] cur_sel;
  logic             fwd_path;
  logic             in_idle;
  logic             hs;
  logic             sop_hs;
  logic             eop_hs;
  logic             drop_sop;

  assign sop_idx = egr_bus_tuser[SEL_W-1:0];
  assign idx_ok  = 32'(sop_idx) < NUM_PORTS;

  // Pad the per-port vectors to the full index range so an out-of-range index
  // reads "congested / not ready" instead of indexing past the end.
  always_comb begin
    af_ext                  = '1;
    af_ext[NUM_PORTS-1:0]   = port_almost_full;
    rdy_ext                 = '0;
    rdy_ext[NUM_PORTS-1:0]  = egr_ports_tready;
  end

  assign admit = idx_ok && !af_ext[sop_idx];

  // Datapath routing: in IDLE the live tuser decides, afterwards the frozen sel.
  always_comb begin
    cur_sel  = sel_q;
    fwd_path = 1'b0;
    in_idle  = 1'b0;
    case (state_q)
      StIdle: begin
        cur_sel  = sop_idx;
        fwd_path = admit;
        in_idle  = 1'b1;
      end
      StFwd:   fwd_path = 1'b1;
      default: fwd_path = 1'b0;
    endcase
  end

  always_comb begin
    if (sreset_ifc) begin
      egr_bus_tready = 1'b0;
    end else if (fwd_path) begin
      egr_bus_tready = rdy_ext[cur_sel];
    end else begin
      // Dropping: sink every beat
      egr_bus_tready = 1'b1;
    end
  end

  assign hs       = egr_bus_tvalid && egr_bus_tready;
  assign sop_hs   = in_idle && hs;
  assign eop_hs   = hs && egr_bus_tlast;
  assign drop_sop = sop_hs && !admit && idx_ok;

  // Next state; a single-beat packet never leaves IDLE
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (sop_hs && !egr_bus_tlast) begin
          state_d = admit ? StFwd : StDrop;
          sel_d   = sop_idx;
        end
      end
      StFwd, StDrop: begin
        if (eop_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_ifc) begin
    if (sreset_ifc) begin
      state_q <= StIdle;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign bad_port_pulse = sop_hs && !idx_ok;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic is_sel;
    assign is_sel = (cur_sel == SEL_W'(p));

    assign egr_ports_tvalid[p] = !sreset_ifc && fwd_path && is_sel && egr_bus_tvalid;
    assign egr_ports_tdata[p]  = egr_bus_tdata;
    assign egr_ports_tkeep[p]  = egr_bus_tkeep;
    assign egr_ports_tlast[p]  = egr_bus_tlast;
    assign egr_ports_tuser[p]  = egr_bus_tuser;

    assign drop_pulse[p] = drop_sop && (sop_idx == SEL_W'(p));

`ifdef MPLS_EGRESS_ADMIT_STATS_EN
    logic fwd_inc;
    // A forwarded packet counts once, on its tlast handshake
    assign fwd_inc = fwd_path && is_sel && eop_hs;

    mpls_egress_port_stats #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_fwd_cnt (
      .clk    (clk_ifc),
      .sreset (sreset_ifc),
      .inc    (fwd_inc),
      .count  (fwd_pkt_cnt[p])
    );

    mpls_egress_port_stats #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_drop_cnt (
      .clk    (clk_ifc),
      .sreset (sreset_ifc),
      .inc    (drop_pulse[p]),
      .count  (drop_pkt_cnt[p])
    );
`else
    assign fwd_pkt_cnt[p]  = '0;
    assign drop_pkt_cnt[p] = '0;
`endif
  end

`ifdef MPLS_EGRESS_ADMIT_STATS_EN
  mpls_egress_port_stats #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bad_cnt (
    .clk    (clk_ifc),
    .sreset (sreset_ifc),
    .inc    (bad_port_pulse),
    .count  (bad_port_cnt)
  );
`else
  assign bad_port_cnt = '0;
`endif

endmodule

// File: tb/tb_mpls_egress_admit.sv
// Bench for mpls_egress_admit (NUM_PORTS=3, CNT_WIDTH=4): a directed vector table,
// hand-written multi-cycle sequences and a randomized run, all checked against a
// packet-level reference model.
module tb_mpls_egress_admit;

  localparam int unsigned NP   = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned DB   = 2;
  localparam int unsigned UW   = 4;
  localparam int unsigned DW   = 8 * DB;
  localparam int          CMAX = (1 << CW) - 1;
`ifdef MPLS_EGRESS_ADMIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   sreset;
  logic                   bus_tvalid;
  logic                   bus_tready;
  logic [DW-1:0]          bus_tdata;
  logic [DB-1:0]          bus_tkeep;
  logic                   bus_tlast;
  logic [UW-1:0]          bus_tuser;
  logic [NP-1:0]          ptvalid;
  logic [NP-1:0]          prdy;
  logic [NP-1:0][DW-1:0]  ptdata;
  logic [NP-1:0][DB-1:0]  ptkeep;
  logic [NP-1:0]          ptlast;
  logic [NP-1:0][UW-1:0]  ptuser;
  logic [NP-1:0]          af;
  logic [NP-1:0]          drop_pulse;
  logic                   bad_pulse;
  logic [NP-1:0][CW-1:0]  fwd_cnt;
  logic [NP-1:0][CW-1:0]  drop_cnt;
  logic [CW-1:0]          bad_cnt;

  always #5 clk = ~clk;

  mpls_egress_admit #(
    .NUM_PORTS  (NP),
    .CNT_WIDTH  (CW),
    .DATA_BYTES (DB),
    .USER_WIDTH (UW)
  ) dut (
    .clk_ifc          (clk),
    .sreset_ifc       (sreset),
    .egr_bus_tvalid   (bus_tvalid),
    .egr_bus_tready   (bus_tready),
    .egr_bus_tdata    (bus_tdata),
    .egr_bus_tkeep    (bus_tkeep),
    .egr_bus_tlast    (bus_tlast),
    .egr_bus_tuser    (bus_tuser),
    .egr_ports_tvalid (ptvalid),
    .egr_ports_tready (prdy),
    .egr_ports_tdata  (ptdata),
    .egr_ports_tkeep  (ptkeep),
    .egr_ports_tlast  (ptlast),
    .egr_ports_tuser  (ptuser),
    .port_almost_full (af),
    .drop_pulse       (drop_pulse),
    .bad_port_pulse   (bad_pulse),
    .fwd_pkt_cnt      (fwd_cnt),
    .drop_pkt_cnt     (drop_cnt),
    .bad_port_cnt     (bad_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: packet-level view
  bit m_in_pkt;          // inside a multi-beat packet
  bit m_fwd;             // that packet is being forwarded
  int m_port;            // destination decided at its SOP
  int m_fwd_cnt [NP];
  int m_drop_cnt[NP];
  int m_bad_cnt;
  // Expectations for the current cycle
  bit          e_tready;
  bit [NP-1:0] e_pvalid;
  bit [NP-1:0] e_drop;
  bit          e_bad;
  bit          e_hs;
  bit          c_fwd;
  int          c_port;
  int          c_idx;
  // Beats seen leaving the DUT
  int            q_port[$];
  logic [DW-1:0] q_data[$];

  typedef struct {
    bit          v;
    logic [3:0]  u;
    bit          l;
    logic [2:0]  a;
    logic [2:0]  r;
    bit          x_tready;
    logic [2:0]  x_pvalid;
    logic [2:0]  x_drop;
    bit          x_bad;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c);
    if (c >= CMAX) return CMAX;
    return c + 1;
  endfunction

  task automatic model_reset();
    m_in_pkt  = 1'b0;
    m_fwd     = 1'b0;
    m_port    = 0;
    m_bad_cnt = 0;
    for (int p = 0; p < NP; p++) begin
      m_fwd_cnt[p]  = 0;
      m_drop_cnt[p] = 0;
    end
  endtask

  task automatic model_outputs();
    c_idx = int'(bus_tuser[1:0]);
    if (!m_in_pkt) begin
      c_port = c_idx;
      c_fwd  = (c_idx < NP) ? !af[c_idx] : 1'b0;
    end else begin
      c_port = m_port;
      c_fwd  = m_fwd;
    end
    e_tready = sreset ? 1'b0 : (c_fwd ? prdy[c_port] : 1'b1);
    e_pvalid = '0;
    if (!sreset && c_fwd && bus_tvalid) e_pvalid[c_port] = 1'b1;
    e_hs   = bus_tvalid && e_tready;
    e_drop = '0;
    e_bad  = 1'b0;
    if (!m_in_pkt && e_hs && !c_fwd) begin
      if (c_idx < NP) e_drop[c_idx] = 1'b1;
      else            e_bad = 1'b1;
    end
  endtask

  task automatic model_update();
    if (sreset) begin
      model_reset();
    end else if (e_hs) begin
      if (!m_in_pkt) begin
        if (!c_fwd) begin
          if (c_idx < NP) m_drop_cnt[c_idx] = sat(m_drop_cnt[c_idx]);
          else            m_bad_cnt = sat(m_bad_cnt);
        end
        if (bus_tlast) begin
          if (c_fwd) m_fwd_cnt[c_port] = sat(m_fwd_cnt[c_port]);
        end else begin
          m_in_pkt = 1'b1;
          m_fwd    = c_fwd;
          m_port   = c_port;
        end
      end else if (bus_tlast) begin
        if (m_fwd) m_fwd_cnt[m_port] = sat(m_fwd_cnt[m_port]);
        m_in_pkt = 1'b0;
      end
    end
  endtask

  task automatic apply(input bit v, input logic [UW-1:0] u, input bit l,
                       input logic [NP-1:0] a, input logic [NP-1:0] r,
                       input logic [DW-1:0] d);
    bus_tvalid = v;
    bus_tuser  = u;
    bus_tlast  = l;
    af         = a;
    prdy       = r;
    bus_tdata  = d;
    bus_tkeep  = DB'($urandom);
  endtask

  // Let inputs settle mid-cycle, then compare outputs against the model
  task automatic settle_check();
    #2;
    model_outputs();
    if (bus_tvalid || sreset) chk("bus_tready", 64'(bus_tready), 64'(e_tready));
    chk("port_tvalid", 64'(ptvalid), 64'(e_pvalid));
    chk("drop_pulse", 64'(drop_pulse), 64'(e_drop));
    chk("bad_port_pulse", 64'(bad_pulse), 64'(e_bad));
    if (e_pvalid != '0) begin
      chk("port_tdata", 64'(ptdata[c_port]), 64'(bus_tdata));
      chk("port_tkeep", 64'(ptkeep[c_port]), 64'(bus_tkeep));
      chk("port_tlast", 64'(ptlast[c_port]), 64'(bus_tlast));
      chk("port_tuser", 64'(ptuser[c_port]), 64'(bus_tuser));
    end
    for (int p = 0; p < NP; p++) begin
      if (ptvalid[p] && prdy[p]) begin
        q_port.push_back(p);
        q_data.push_back(ptdata[p]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    for (int p = 0; p < NP; p++) begin
      chk("fwd_pkt_cnt", 64'(fwd_cnt[p]), STATS ? 64'(m_fwd_cnt[p]) : 64'd0);
      chk("drop_pkt_cnt", 64'(drop_cnt[p]), STATS ? 64'(m_drop_cnt[p]) : 64'd0);
    end
    chk("bad_port_cnt", 64'(bad_cnt), STATS ? 64'(m_bad_cnt) : 64'd0);
  endtask

  task automatic cyc(input bit v, input logic [UW-1:0] u, input bit l,
                     input logic [NP-1:0] a, input logic [NP-1:0] r);
    apply(v, u, l, a, r, DW'($urandom));
    settle_check();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d_a, d_b, d_c;

    //     v  u  l  af      rdy     trdy pvalid  drop    bad
    tbl[0]  = '{1, 2, 0, 3'b000, 3'b111, 1, 3'b100, 3'b000, 0}; // 3-beat to port 2
    tbl[1]  = '{1, 0, 0, 3'b000, 3'b111, 1, 3'b100, 3'b000, 0}; // tuser ignored
    tbl[2]  = '{1, 1, 1, 3'b000, 3'b111, 1, 3'b100, 3'b000, 0};
    tbl[3]  = '{1, 1, 0, 3'b010, 3'b111, 1, 3'b000, 3'b010, 0}; // port 1 congested
    tbl[4]  = '{1, 1, 0, 3'b000, 3'b111, 1, 3'b000, 3'b000, 0};
    tbl[5]  = '{1, 1, 0, 3'b000, 3'b011, 1, 3'b000, 3'b000, 0};
    tbl[6]  = '{1, 1, 1, 3'b000, 3'b111, 1, 3'b000, 3'b000, 0};
    tbl[7]  = '{1, 3, 0, 3'b000, 3'b111, 1, 3'b000, 3'b000, 1}; // out-of-range index
    tbl[8]  = '{1, 3, 1, 3'b000, 3'b111, 1, 3'b000, 3'b000, 0};
    tbl[9]  = '{1, 0, 1, 3'b000, 3'b110, 0, 3'b001, 3'b000, 0}; // port 0 stalled
    tbl[10] = '{1, 0, 1, 3'b000, 3'b111, 1, 3'b001, 3'b000, 0};

    model_reset();
    sreset = 1'b1;
    cyc(1, 0, 0, 3'b000, 3'b111);
    cyc(1, 2, 0, 3'b000, 3'b111);
    sreset = 1'b0;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].v, tbl[i].u, tbl[i].l, tbl[i].a, tbl[i].r, DW'($urandom));
      settle_check();
      chk("tbl_tready", 64'(bus_tready), 64'(tbl[i].x_tready));
      chk("tbl_pvalid", 64'(ptvalid), 64'(tbl[i].x_pvalid));
      chk("tbl_drop", 64'(drop_pulse), 64'(tbl[i].x_drop));
      chk("tbl_bad", 64'(bad_pulse), 64'(tbl[i].x_bad));
      tick();
    end
    chk("tbl_fwd2", 64'(fwd_cnt[2]), STATS ? 64'd1 : 64'd0);
    chk("tbl_fwd0", 64'(fwd_cnt[0]), STATS ? 64'd1 : 64'd0);
    chk("tbl_drop1", 64'(drop_cnt[1]), STATS ? 64'd1 : 64'd0);
    chk("tbl_bad", 64'(bad_cnt), STATS ? 64'd1 : 64'd0);

    // Congestion and tuser change after SOP must not disturb a 5-beat packet
    q_port.delete();
    q_data.delete();
    cyc(1, 0, 0, 3'b000, 3'b111);
    for (int b = 1; b < 5; b++) begin
      apply(1, 4'd2, (b == 4), 3'b111, 3'b111, DW'($urandom));
      settle_check();
      chk("midpkt_route", 64'(ptvalid), 64'(3'b001));
      tick();
    end
    chk("midpkt_beats", 64'(q_port.size()), 64'd5);
    chk("midpkt_fwd0", 64'(fwd_cnt[0]), STATS ? 64'd2 : 64'd0);

    // Back-to-back single-beat packets 0,1,0 with port 1 stalled 3 cycles
    q_port.delete();
    q_data.delete();
    d_a = 16'hA0A0;
    d_b = 16'hB1B1;
    d_c = 16'hC0C0;
    apply(1, 0, 1, 3'b000, 3'b111, d_a);
    settle_check();
    tick();
    for (int s = 0; s < 3; s++) begin
      apply(1, 1, 1, 3'b000, 3'b101, d_b);
      settle_check();
      chk("stall_tready", 64'(bus_tready), 64'd0);
      chk("stall_pvalid", 64'(ptvalid), 64'(3'b010));
      tick();
    end
    apply(1, 1, 1, 3'b000, 3'b111, d_b);
    settle_check();
    tick();
    apply(1, 0, 1, 3'b000, 3'b111, d_c);
    settle_check();
    chk("b2b_route_c", 64'(ptvalid), 64'(3'b001));
    tick();
    chk("b2b_count", 64'(q_port.size()), 64'd3);
    if (q_port.size() == 3) begin
      chk("b2b_order0", {32'(q_port[0]), 32'(q_data[0])}, {32'd0, 32'(d_a)});
      chk("b2b_order1", {32'(q_port[1]), 32'(q_data[1])}, {32'd1, 32'(d_b)});
      chk("b2b_order2", {32'(q_port[2]), 32'(q_data[2])}, {32'd0, 32'(d_c)});
    end
    chk("b2b_fwd0", 64'(fwd_cnt[0]), STATS ? 64'd4 : 64'd0);
    chk("b2b_fwd1", 64'(fwd_cnt[1]), STATS ? 64'd1 : 64'd0);

    // Saturation: 17 more packets to port 2
    for (int k = 0; k < 17; k++) cyc(1, 2, 1, 3'b000, 3'b111);
    chk("sat_fwd2", 64'(fwd_cnt[2]), STATS ? 64'(CMAX) : 64'd0);

    // Reset mid-packet abandons it; next beat is an SOP
    cyc(1, 1, 0, 3'b000, 3'b111);
    cyc(1, 1, 0, 3'b000, 3'b111);
    sreset = 1'b1;
    apply(1, 1, 0, 3'b000, 3'b111, DW'($urandom));
    settle_check();
    chk("rst_tready", 64'(bus_tready), 64'd0);
    chk("rst_pvalid", 64'(ptvalid), 64'd0);
    tick();
    chk("rst_fwd2", 64'(fwd_cnt[2]), 64'd0);
    chk("rst_bad", 64'(bad_cnt), 64'd0);
    sreset = 1'b0;
    apply(1, 2, 0, 3'b000, 3'b111, DW'($urandom));
    settle_check();
    chk("post_rst_sop", 64'(ptvalid), 64'(3'b100));
    tick();
    cyc(1, 1, 1, 3'b000, 3'b111);
    chk("post_rst_fwd2", 64'(fwd_cnt[2]), STATS ? 64'd1 : 64'd0);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      sreset = ($urandom_range(0, 299) == 0);
      cyc(($urandom_range(0, 9) < 7), UW'($urandom), ($urandom_range(0, 3) == 0),
          NP'($urandom & $urandom), NP'($urandom | $urandom));
    end
    sreset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
